complex_mxv_batch_scheduler: RTL and testbench

// Sequences the complex matrix-by-vector engine over a full matrix. Splits total_rows into batches of
// NO_OF_LANES rows, fetches each batch from A/vector memories, starts the row-by-vector lanes and

---
 rtl/complex_mxv_batch_scheduler.sv | 169 ++++++++++++++++
 tb/tb_complex_mxv_batch_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mxv_batch_scheduler.sv
// Batch scheduler for the complex matrix-by-vector engine.
// Walks a matrix in batches of NO_OF_LANES rows: fetch, wait for memory,
// arm the row lanes, collect their done pulses, then wait for the decoder
// to drain every batch before reporting finish.
module complex_mxv_batch_scheduler #(
  parameter int NO_OF_LANES = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               total_rows,
  input  logic [31:0]               multiples,
  input  logic [NO_OF_LANES-1:0]    lane_ready,
  input  logic [NO_OF_LANES-1:0]    lane_done,
  input  logic                      result_valid,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     row_addr,
  output logic [NO_OF_LANES-1:0]    lane_start,
  output logic [32*NO_OF_LANES-1:0] lane_multiples,
  output logic                      busy,
  output logic                      finish
);

  localparam int LATW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ARM, S_WAIT, S_DRAIN, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              rows_q, rows_d;
  logic [31:0]              mult_q, mult_d;
  logic [31:0]              nbatches_q, nbatches_d;
  logic [31:0]              batch_idx_q, batch_idx_d;
  logic [31:0]              drain_cnt_q, drain_cnt_d;
  logic [NO_OF_LANES-1:0]   done_mask_q, done_mask_d;
  logic [LATW-1:0]          lat_cnt_q, lat_cnt_d;
  logic [32*NO_OF_LANES-1:0] lane_mult_q, lane_mult_d;

  logic [63:0]              base_row;
  logic [NO_OF_LANES-1:0]   act_mask;
  logic [NO_OF_LANES-1:0]   done_new;
  logic                     busy_s;
  logic                     lanes_rdy;

  // Active-lane mask of the current batch: a lane is live only while its row exists.
  always_comb begin
    base_row = 64'(batch_idx_q) * 64'(NO_OF_LANES);
    act_mask = '0;
    for (int k = 0; k < NO_OF_LANES; k++) begin
      act_mask[k] = (base_row + 64'(k)) < 64'(rows_q);
    end
  end

  assign done_new  = done_mask_q | (lane_done & act_mask);
  assign busy_s    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign lanes_rdy = (lane_ready & act_mask) == act_mask;

  assign mem_rd_en      = (state_q == S_FETCH);
  assign row_addr       = ADDR_WIDTH'(base_row);
  // Start is gated by the run level so an aborting cycle never launches a batch.
  assign lane_start     = (state_q == S_ARM && start && lanes_rdy) ? act_mask : '0;
  assign lane_multiples = lane_mult_q;
  assign busy           = busy_s;
  assign finish         = (state_q == S_DONE);

  // Next-state logic: batch sequencing, done collection, drain counting and abort.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    mult_d      = mult_q;
    nbatches_d  = nbatches_q;
    batch_idx_d = batch_idx_q;
    drain_cnt_d = drain_cnt_q;
    done_mask_d = done_mask_q;
    lat_cnt_d   = lat_cnt_q;
    lane_mult_d = lane_mult_q;

    // Decoder pulses may arrive before DRAIN; extra pulses beyond nbatches are dropped.
    if (busy_s && result_valid && (drain_cnt_q < nbatches_q)) begin
      drain_cnt_d = drain_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d      = total_rows;
          mult_d      = multiples;
          nbatches_d  = 32'((33'(total_rows) + 33'(NO_OF_LANES - 1)) / 33'(NO_OF_LANES));
          batch_idx_d = '0;
          drain_cnt_d = '0;
          done_mask_d = '0;
          state_d     = (total_rows != 32'd0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        lat_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (lat_cnt_q == LATW'(MEM_LATENCY - 1)) begin
          state_d = S_ARM;
          for (int k = 0; k < NO_OF_LANES; k++) begin
            lane_mult_d[k*32 +: 32] = act_mask[k] ? mult_q : 32'd0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LATW'(1);
        end
      end
      S_ARM: begin
        if (lanes_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_new == act_mask) begin
          done_mask_d = '0;
          batch_idx_d = batch_idx_q + 32'd1;
          state_d     = ((batch_idx_q + 32'd1) < nbatches_q) ? S_FETCH : S_DRAIN;
        end else begin
          done_mask_d = done_new;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == nbatches_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping start is a synchronous abort from any state.
    if (!start) begin
      state_d     = S_IDLE;
      batch_idx_d = '0;
      drain_cnt_d = '0;
      done_mask_d = '0;
      lat_cnt_d   = '0;
      lane_mult_d = '0;
    end
  end

  // State and bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      mult_q      <= '0;
      nbatches_q  <= '0;
      batch_idx_q <= '0;
      drain_cnt_q <= '0;
      done_mask_q <= '0;
      lat_cnt_q   <= '0;
      lane_mult_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      mult_q      <= mult_d;
      nbatches_q  <= nbatches_d;
      batch_idx_q <= batch_idx_d;
      drain_cnt_q <= drain_cnt_d;
      done_mask_q <= done_mask_d;
      lat_cnt_q   <= lat_cnt_d;
      lane_mult_q <= lane_mult_d;
    end
  end

endmodule

// File: tb/tb_complex_mxv_batch_scheduler.sv
// Testbench for complex_mxv_batch_scheduler (NO_OF_LANES=4, MEM_LATENCY=1).
module tb_complex_mxv_batch_scheduler;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  total_rows;
  logic [31:0]  multiples;
  logic [L-1:0] lane_ready;
  logic [L-1:0] lane_done;
  logic         result_valid;
  logic         mem_rd_en;
  logic [15:0]  row_addr;
  logic [L-1:0] lane_start;
  logic [32*L-1:0] lane_multiples;
  logic         busy;
  logic         finish;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  complex_mxv_batch_scheduler #(.NO_OF_LANES(L), .ADDR_WIDTH(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .total_rows(total_rows), .multiples(multiples),
    .lane_ready(lane_ready), .lane_done(lane_done), .result_valid(result_valid),
    .mem_rd_en(mem_rd_en), .row_addr(row_addr), .lane_start(lane_start),
    .lane_multiples(lane_multiples), .busy(busy), .finish(finish)
  );

  // Reference model: batch count and per-batch lane occupancy from the row count.
  function automatic int nbatches(input int rows);
    return (rows + L - 1) / L;
  endfunction

  function automatic logic [L-1:0] exp_mask(input int b, input int rows);
    logic [L-1:0] m;
    for (int k = 0; k < L; k++) m[k] = (b * L + k) < rows;
    return m;
  endfunction

  function automatic logic [32*L-1:0] exp_mult(input logic [L-1:0] m, input logic [31:0] mu);
    logic [32*L-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) if (m[k]) r[k*32 +: 32] = mu;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for 0: mem_rd_en, 1: lane_start nonzero, 2: finish.
  task automatic wait_out(input int which, input int bound, output bit to);
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if ((which == 0 && mem_rd_en === 1'b1) || (which == 1 && lane_start !== '0) ||
          (which == 2 && finish === 1'b1)) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; total_rows = '0; multiples = '0;
    lane_ready = '0; lane_done = '0; result_valid = 1'b0;
    #12;
    chk_cnt++; if (mem_rd_en !== 1'b0) $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); else pass_cnt++;
    chk_cnt++; if (row_addr !== 16'd0) $display("FAIL reset_row_addr: got %0d want 0", row_addr); else pass_cnt++;
    chk_cnt++; if (lane_start !== 4'd0) $display("FAIL reset_lane_start: got %b want 0000", lane_start); else pass_cnt++;
    chk_cnt++; if (lane_multiples !== '0) $display("FAIL reset_lane_multiples: got %h want 0", lane_multiples); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", finish); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    total_rows = 32'd4; multiples = 32'h1234_5678; lane_ready = '1; start = 1'b1;
    tick();
    chk_cnt++; if (mem_rd_en !== 1'b1 || row_addr !== 16'd0) $display("FAIL lat_fetch: got mem=%b addr=%0d want mem=1 addr=0", mem_rd_en, row_addr); else pass_cnt++;
    tick();
    chk_cnt++; if (mem_rd_en !== 1'b0 || lane_start !== 4'd0) $display("FAIL lat_load: got mem=%b start=%b want 0/0000", mem_rd_en, lane_start); else pass_cnt++;
    tick();
    chk_cnt++; if (lane_start !== 4'b1111) $display("FAIL lat_lane_start: got %b want 1111", lane_start); else pass_cnt++;
    tick();
    chk_cnt++; if (lane_start !== 4'd0 || busy !== 1'b1) $display("FAIL lat_start_pulse: got start=%b busy=%b want 0000/1", lane_start, busy); else pass_cnt++;
    lane_done = 4'b1111; tick(); lane_done = '0;
    chk_cnt++; if (mem_rd_en !== 1'b0 || finish !== 1'b0) $display("FAIL lat_drain: got mem=%b fin=%b want 0/0", mem_rd_en, finish); else pass_cnt++;
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    chk_cnt++; if (finish !== 1'b0) $display("FAIL lat_fin_early: got %b want 0", finish); else pass_cnt++;
    tick();
    chk_cnt++; if (finish !== 1'b1 || busy !== 1'b0) $display("FAIL lat_finish: got fin=%b busy=%b want 1/0", finish, busy); else pass_cnt++;
    start = 1'b0; tick();
    chk_cnt++; if (finish !== 1'b0) $display("FAIL lat_finish_clear: got %b want 0", finish); else pass_cnt++;
  endtask

  task automatic test_zero_rows();
    bit seen_mem;
    total_rows = 32'd0; start = 1'b1;
    seen_mem = 1'b0;
    tick(); seen_mem |= mem_rd_en;
    tick(); seen_mem |= mem_rd_en;
    chk_cnt++; if (finish !== 1'b1 || busy !== 1'b0) $display("FAIL zero_finish: got fin=%b busy=%b want 1/0", finish, busy); else pass_cnt++;
    tick(); seen_mem |= mem_rd_en;
    chk_cnt++; if (seen_mem !== 1'b0) $display("FAIL zero_no_fetch: got mem seen=%b want 0", seen_mem); else pass_cnt++;
    start = 1'b0; tick();
  endtask

  task automatic test_random_jobs();
    int rl[7];
    rl = '{8, 6, 1, 5, 13, 4, 0};
    rl[6] = $urandom_range(1, 20);
    for (int j = 0; j < 7; j++) begin
      int rows, nb, sent;
      logic [31:0] mu;
      logic [L-1:0] m, rem, sub;
      bit to;
      rows = rl[j]; nb = nbatches(rows); sent = 0; mu = $urandom;
      total_rows = rows; multiples = mu; lane_ready = '1; start = 1'b1;
      for (int b = 0; b < nb; b++) begin
        wait_out(0, 20, to);
        chk_cnt++; if (to || row_addr !== 16'(b * L)) $display("FAIL job%0d_fetch b%0d: timeout=%0b addr=%0d want addr=%0d", j, b, to, row_addr, b * L); else pass_cnt++;
        if (b == 0) begin total_rows = $urandom; multiples = $urandom; end
        wait_out(1, 20, to);
        m = exp_mask(b, rows);
        chk_cnt++; if (to || lane_start !== m) $display("FAIL job%0d_lane_start b%0d: timeout=%0b got %b want %b", j, b, to, lane_start, m); else pass_cnt++;
        chk_cnt++; if (lane_multiples !== exp_mult(m, mu)) $display("FAIL job%0d_multiples b%0d: got %h want %h", j, b, lane_multiples, exp_mult(m, mu)); else pass_cnt++;
        tick();
        rem = m;
        while (rem != '0) begin
          sub = L'($urandom) & rem;
          if (sub == '0) sub = rem;
          lane_done = sub | (L'($urandom) & ~m);
          if (sent < nb - 1 && $urandom_range(0, 1) == 1) begin result_valid = 1'b1; sent++; end
          rem &= ~sub;
          tick();
          lane_done = '0; result_valid = 1'b0;
          if (rem != '0) begin
            chk_cnt++; if (mem_rd_en !== 1'b0 || finish !== 1'b0) $display("FAIL job%0d_early_advance b%0d: got mem=%b fin=%b want 0/0", j, b, mem_rd_en, finish); else pass_cnt++;
          end
        end
      end
      while (sent < nb) begin
        chk_cnt++; if (finish !== 1'b0) $display("FAIL job%0d_early_finish: got %b want 0 with %0d/%0d drained", j, finish, sent, nb); else pass_cnt++;
        result_valid = 1'b1; tick(); result_valid = 1'b0; sent++; tick();
      end
      wait_out(2, 5, to);
      chk_cnt++; if (to || busy !== 1'b0) $display("FAIL job%0d_finish: timeout=%0b busy=%b want finish and busy=0", j, to, busy); else pass_cnt++;
      start = 1'b0; tick();
      chk_cnt++; if (finish !== 1'b0 || busy !== 1'b0) $display("FAIL job%0d_release: got fin=%b busy=%b want 0/0", j, finish, busy); else pass_cnt++;
    end
  endtask

  task automatic test_stagger();
    logic [L-1:0] pulses[4];
    bit to;
    pulses = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    total_rows = 32'd8; multiples = 32'd3; lane_ready = '1; start = 1'b1;
    wait_out(1, 20, to);
    tick();
    for (int i = 0; i < 4; i++) begin
      lane_done = pulses[i]; tick(); lane_done = '0;
      if (i < 3) begin
        chk_cnt++; if (mem_rd_en !== 1'b0) $display("FAIL stagger_premature_fetch p%0d: got %b want 0", i, mem_rd_en); else pass_cnt++;
      end
    end
    chk_cnt++; if (mem_rd_en !== 1'b1 || row_addr !== 16'd4) $display("FAIL stagger_fetch2: got mem=%b addr=%0d want 1/4", mem_rd_en, row_addr); else pass_cnt++;
    wait_out(1, 20, to);
    chk_cnt++; if (to || lane_start !== 4'b1111) $display("FAIL stagger_start2: timeout=%0b got %b want 1111", to, lane_start); else pass_cnt++;
    tick(); lane_done = 4'b1111; tick(); lane_done = '0;
    for (int i = 0; i < 2; i++) begin result_valid = 1'b1; tick(); result_valid = 1'b0; tick(); end
    wait_out(2, 5, to);
    chk_cnt++; if (to) $display("FAIL stagger_finish: got timeout want finish"); else pass_cnt++;
    start = 1'b0; tick();
  endtask

  task automatic test_ready_gating();
    bit to;
    total_rows = 32'd4; multiples = 32'd9; lane_ready = 4'b1011; start = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (lane_start !== 4'd0) $display("FAIL gate_hold c%0d: got %b want 0000", i, lane_start); else pass_cnt++;
      if (i < 2) tick();
    end
    lane_ready = 4'b1111; #1;
    chk_cnt++; if (lane_start !== 4'b1111) $display("FAIL gate_release: got %b want 1111", lane_start); else pass_cnt++;
    tick(); lane_done = 4'b1111; tick(); lane_done = '0;
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_out(2, 5, to);
    chk_cnt++; if (to) $display("FAIL gate_finish: got timeout want finish"); else pass_cnt++;
    start = 1'b0; tick();
  endtask

  task automatic test_abort();
    bit to;
    total_rows = 32'd8; multiples = 32'd5; lane_ready = '1; start = 1'b1;
    wait_out(1, 20, to);
    tick();
    lane_done = 4'b0001; result_valid = 1'b1; tick(); lane_done = '0; result_valid = 1'b0;
    start = 1'b0; tick();
    chk_cnt++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || finish !== 1'b0) $display("FAIL abort_idle: got busy=%b mem=%b fin=%b want 0/0/0", busy, mem_rd_en, finish); else pass_cnt++;
    chk_cnt++; if (lane_multiples !== '0 || lane_start !== 4'd0) $display("FAIL abort_outputs: got mult=%h start=%b want 0", lane_multiples, lane_start); else pass_cnt++;
    total_rows = 32'd4; multiples = 32'hCAFE_0001; start = 1'b1;
    wait_out(0, 20, to);
    chk_cnt++; if (to || row_addr !== 16'd0) $display("FAIL abort_restart_addr: timeout=%0b addr=%0d want 0", to, row_addr); else pass_cnt++;
    wait_out(1, 20, to);
    chk_cnt++; if (to || lane_multiples !== exp_mult(4'b1111, 32'hCAFE_0001)) $display("FAIL abort_restart_mult: timeout=%0b got %h", to, lane_multiples); else pass_cnt++;
    tick();
    lane_done = 4'b1110; tick(); lane_done = '0; tick(); tick();
    chk_cnt++; if (finish !== 1'b0 || busy !== 1'b1) $display("FAIL abort_stale_mask: got fin=%b busy=%b want 0/1", finish, busy); else pass_cnt++;
    lane_done = 4'b0001; tick(); lane_done = '0; tick(); tick(); tick();
    chk_cnt++; if (finish !== 1'b0) $display("FAIL abort_stale_drain: got fin=%b want 0", finish); else pass_cnt++;
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_out(2, 5, to);
    chk_cnt++; if (to) $display("FAIL abort_restart_finish: got timeout want finish"); else pass_cnt++;
    start = 1'b0; tick();
  endtask

  task automatic test_reset_mid_drain();
    bit to;
    total_rows = 32'd4; multiples = 32'd7; lane_ready = '1; start = 1'b1;
    wait_out(1, 20, to);
    tick(); lane_done = 4'b1111; tick(); lane_done = '0; tick();
    chk_cnt++; if (busy !== 1'b1 || finish !== 1'b0) $display("FAIL mid_drain_state: got busy=%b fin=%b want 1/0", busy, finish); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0 || finish !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL async_reset_ctrl: got busy=%b fin=%b mem=%b want 0/0/0", busy, finish, mem_rd_en); else pass_cnt++;
    chk_cnt++; if (lane_multiples !== '0 || row_addr !== 16'd0) $display("FAIL async_reset_data: got mult=%h addr=%0d want 0", lane_multiples, row_addr); else pass_cnt++;
    start = 1'b0; result_valid = 1'b1; tick(); result_valid = 1'b0; tick();
    reset = 1'b1; tick(); tick();
    chk_cnt++; if (finish !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset_finish: got fin=%b busy=%b want 0/0", finish, busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_zero_rows();
    test_random_jobs();
    test_stagger();
    test_ready_gating();
    test_abort();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
